// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module : seq_det_pkg
// Brief  : Shared constants and helpers for the programmable sequence detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int         C_DEFAULT_LEN     = 5;
    // Bit 0 is the first bit received: sequence 1,0,1,1,0.
    localparam logic [7:0] C_DEFAULT_PATTERN = 8'h0D;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_cmp.sv
// ============================================================================
// Module : seq_det_cmp
// Brief  : Combinational masked compare of {history, current bit} against the
//          programmed pattern for a runtime length.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_det_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-2:0] i_hist,
    input  logic               i_a,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [MAX_LEN-1:0] i_mask,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_hit
);

    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_rev;
    logic [MAX_LEN-1:0] w_aligned;
    logic [MAX_LEN-1:0] w_lenmask;
    logic [MAX_LEN-1:0] w_diff;
    logic [LEN_W-1:0]   w_shamt;

    // w_win[0] is the current bit, w_win[j] the bit received j accepts ago.
    assign w_win = {i_hist, i_a};

    always_comb begin
        w_rev     = '0;
        w_lenmask = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            w_rev[MAX_LEN-1-j] = w_win[j];
            w_lenmask[j]       = (LEN_W'(j) < i_len);
        end
    end

    // After the shift, bit k lines up with pattern bit k (oldest bit at k=0).
    assign w_shamt   = LEN_W'(MAX_LEN) - i_len;
    assign w_aligned = w_rev >> w_shamt;
    assign w_diff    = (w_aligned ^ i_pattern) & ~i_mask & w_lenmask;
    assign o_hit     = (i_len != '0) && (w_diff == '0);

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ============================================================================
// Module : seq_detector_prog
// Brief  : Runtime-programmable serial pattern detector with Mealy match,
//          registered pulse and saturating counter. SEQ_DET_MASK_EN adds a
//          per-bit don't-care mask port (cfg_mask).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter int                 DEFAULT_LEN     = C_DEFAULT_LEN,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(C_DEFAULT_PATTERN),
    parameter int                 LEN_W           = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               a,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    output logic               y,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match_q;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_accept;
    logic               w_fill_ok;
    logic               w_hit;
    logic               w_y;

`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] r_mask;
    assign w_mask = r_mask;
`else
    assign w_mask = '0;
`endif

    assign w_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    assign w_accept      = en & ~cfg_load;
    // fill >= len-1 rewritten to avoid underflow when len is 0.
    assign w_fill_ok     = (r_fill + LEN_W'(1)) >= r_len;

    seq_det_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .i_hist    (r_hist),
        .i_a       (a),
        .i_pattern (r_pattern),
        .i_mask    (w_mask),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    assign w_y = ~reset & w_accept & (r_len != '0) & w_fill_ok & w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= DEFAULT_PATTERN;
            r_len     <= LEN_W'(DEFAULT_LEN);
            r_overlap <= OVL_ON;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match_q <= 1'b0;
            r_cnt     <= '0;
`ifdef SEQ_DET_MASK_EN
            r_mask    <= '0;
`endif
        end else begin
            r_match_q <= w_y;
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_len_clamped;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
                r_cnt     <= '0;
`ifdef SEQ_DET_MASK_EN
                r_mask    <= cfg_mask;
`endif
            end else begin
                if (en) begin
                    r_hist <= (MAX_LEN-1)'({r_hist, a});
                    // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
                    if (w_y && (r_overlap == OVL_OFF)) begin
                        r_fill <= '0;
                    end else if (r_fill != LEN_W'(MAX_LEN-1)) begin
                        r_fill <= r_fill + LEN_W'(1);
                    end
                end
                if (w_y && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign y         = w_y;
    assign match_q   = r_match_q;
    assign match_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// ============================================================================
// Module : tb_seq_detector_prog
// Brief  : Self-checking bench: queue-based reference model checked every
//          cycle, plus directed vectors with literal expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       a = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b1;
    logic [7:0] cfg_mask = '0;
    logic       y;
    logic       match_q;
    logic [7:0] match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detector_prog dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .a           (a),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .y           (y),
        .match_q     (match_q),
        .match_cnt   (match_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: config plus the list of bits accepted since the last clear.
    logic [7:0] m_pat;
    logic [7:0] m_mask;
    int         m_len;
    bit         m_ovl;
    bit         mq[$];
    int         m_cnt;
    bit         m_mq;

    function automatic bit model_y(bit e, bit ld, bit b);
        bit s;
        if (!e || ld || m_len == 0) return 1'b0;
        if (mq.size() < m_len - 1) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            s = (k == m_len - 1) ? b : mq[mq.size() - (m_len - 1) + k];
            if (!m_mask[k] && (s != m_pat[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        bit       e_y, se, sl, sb, so;
        logic [7:0] sp, sm;
        int       slen;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_pat = 8'h0D; m_len = 5; m_ovl = 1'b1; m_mask = '0;
                mq.delete(); m_cnt = 0; m_mq = 1'b0;
            end
            e_y = reset ? 1'b0 : model_y(en, cfg_load, a);
            chk("y", y, e_y);
            chk("match_q", match_q, m_mq);
            chk("match_cnt", match_cnt, m_cnt);
            se = en; sl = cfg_load; sb = a; sp = cfg_pattern;
            slen = cfg_len; so = cfg_overlap; sm = cfg_mask;
            @(posedge clk);
            if (!reset) begin
                if (sl) begin
                    m_pat = sp;
                    m_len = (slen > 8) ? 8 : slen;
                    m_ovl = so;
`ifdef SEQ_DET_MASK_EN
                    m_mask = sm;
`else
                    m_mask = '0;
`endif
                    mq.delete();
                    m_cnt = 0;
                end else if (se) begin
                    if (e_y && !m_ovl) mq.delete();
                    else begin
                        mq.push_back(sb);
                        if (mq.size() > 8) void'(mq.pop_front());
                    end
                end
                if (e_y && m_cnt < 255) m_cnt++;
                m_mq = e_y;
            end
        end
    end

    task automatic step(input bit e, input bit b, input int xy);
        en = e; a = b; cfg_load = 1'b0;
        @(negedge clk);
        if (xy >= 0) chk("y_lit", y, xy);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                        input logic [7:0] msk);
        cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        cfg_mask = msk; en = 1'b1; a = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic seq(input bit bits[], input int exp[]);
        for (int i = 0; i < bits.size(); i++) step(1'b1, bits[i], exp[i]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_match_q", match_q, 0);
        chk("rst_cnt", match_cnt, 0);
        reset = 1'b0;

        // Default pattern 1,0,1,1,0.
        seq('{1,0,1,1,0}, '{0,0,0,0,1});
        chk("dflt_match_q", match_q, 1);
        chk("dflt_cnt", match_cnt, 1);
        step(1'b0, 1'b0, 0);
        chk("dflt_match_q_pulse", match_q, 0);

        // Length-2 pattern 11, overlapping then non-overlapping.
        load(8'b11, 4'd2, 1'b1, 8'h00);
        seq('{1,1,1,1}, '{0,1,1,1});
        chk("ovl_cnt", match_cnt, 3);
        load(8'b11, 4'd2, 1'b0, 8'h00);
        seq('{1,1,1,1}, '{0,1,0,1});
        chk("novl_cnt", match_cnt, 2);

        // en gaps hold state.
        load(8'b101, 4'd3, 1'b1, 8'h00);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        chk("en_cnt", match_cnt, 1);

        // cfg_load on the completing bit discards it and clears history.
        load(8'b101, 4'd3, 1'b1, 8'h00);
        seq('{1,0}, '{0,0});
        cfg_load = 1'b1; en = 1'b1; a = 1'b1;
        @(negedge clk);
        chk("load_y", y, 0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        chk("load_cnt", match_cnt, 0);
        seq('{1,0,1}, '{0,0,1});

        // Oversized length clamps to 8.
        load(8'hFF, 4'd12, 1'b1, 8'h00);
        seq('{1,1,1,1,1,1,1,1}, '{0,0,0,0,0,0,0,1});

        // Length 0 disables detection.
        load(8'h00, 4'd0, 1'b1, 8'h00);
        seq('{0,0,0,0}, '{0,0,0,0});

        // Counter saturation.
        load(8'h01, 4'd1, 1'b1, 8'h00);
        for (int i = 0; i < 260; i++) step(1'b1, 1'b1, -1);
        chk("sat_cnt", match_cnt, 255);

        // Reset mid-pattern.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seq('{1,0,1,1,0}, '{0,0,0,0,1});
        seq('{1,0,1,1}, '{-1,-1,-1,-1});
        en = 1'b1; a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_y", y, 0);
        chk("midrst_cnt", match_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 0);

`ifdef SEQ_DET_MASK_EN
        // Middle bit is don't-care.
        load(8'b101, 4'd3, 1'b0, 8'b010);
        seq('{1,0,1}, '{0,0,1});
        seq('{1,1,1}, '{0,0,1});
        chk("mask_cnt", match_cnt, 2);
`endif

        step(1'b0, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
